// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready handshakes, a registered
// result stage carrying zero/parity flags, and an accumulator usable as operand A.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result register holds nothing, out_valid=0
// ST_FULL  | result register holds a result, out_valid=1
module logic_unit_pipe #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_q
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             accept;

  assign in_ready   = (state_q == ST_EMPTY) || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_FULL);
  assign out_y      = y_q;
  assign out_zero   = zero_q;
  assign out_parity = par_q;

  // Operand A comes from the pre-clear accumulator even when acc_clr is set.
  assign op_a = in_acc ? acc_q : in_a;

  always_comb begin
    result = '0;
    case (in_op)
      3'd0:    result = op_a & in_b;
      3'd1:    result = op_a | in_b;
      3'd2:    result = ~op_a;
      3'd3:    result = ~(op_a & in_b);
      3'd4:    result = ~(op_a | in_b);
      3'd5:    result = op_a ^ in_b;
      3'd6:    result = ~(op_a ^ in_b);
      default: result = in_b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    par_d   = par_q;
    acc_d   = acc_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      y_d    = result;
      zero_d = ~|result;
      par_d  = ^result;
      acc_d  = result;
    end
    if (acc_clr) acc_d = ACC_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      zero_q  <= 1'b1;
      par_q   <= 1'b0;
      acc_q   <= ACC_INIT;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus a randomized
// stream scored against a truth-table reference model and a result queue.
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] ACC_INIT = 8'h00;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_acc = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_parity;
  logic [WIDTH-1:0] acc_q;

  int checks = 0;
  int failures = 0;

  logic [3:0] tt [8];

  logic_unit_pipe #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_parity(out_parity), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  // Per-bit truth tables indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    logic [3:0] t;
    t = tt[op];
    for (int i = 0; i < WIDTH; i++) y[i] = t[{a[i], b[i]}];
    return y;
  endfunction

  function automatic logic ref_par(input logic [WIDTH-1:0] y);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) if (y[i]) n++;
    return (n % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", out_y); end
    checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", out_zero); end
    checks++; if (out_parity !== 1'b0) begin failures++; $display("FAIL reset_parity got=%b exp=0", out_parity); end
    checks++; if (acc_q !== ACC_INIT) begin failures++; $display("FAIL reset_acc got=%h exp=%h", acc_q, ACC_INIT); end
    #3 rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_opcodes();
    logic [7:0] exp_tab [8];
    exp_tab[0] = 8'h81; exp_tab[1] = 8'hE7; exp_tab[2] = 8'h3C; exp_tab[3] = 8'h7E;
    exp_tab[4] = 8'h18; exp_tab[5] = 8'h66; exp_tab[6] = 8'h99; exp_tab[7] = 8'hA5;
    out_ready = 1'b1; in_acc = 1'b0;
    for (int op = 0; op < 8; op++) begin
      in_valid = 1'b1; in_a = 8'hC3; in_b = 8'hA5; in_op = 3'(op);
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL op%0d_valid got=%b exp=1", op, out_valid); end
      checks++; if (out_y !== exp_tab[op]) begin failures++; $display("FAIL op%0d_y got=%h exp=%h", op, out_y, exp_tab[op]); end
      checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL op%0d_zero got=%b exp=0", op, out_zero); end
      checks++; if (out_parity !== ref_par(exp_tab[op])) begin failures++; $display("FAIL op%0d_parity got=%b exp=%b", op, out_parity, ref_par(exp_tab[op])); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL op_drain_valid got=%b exp=0", out_valid); end
    checks++; if (acc_q !== 8'hA5) begin failures++; $display("FAIL op_acc got=%h exp=a5", acc_q); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd5; in_a = 8'hFF; in_b = 8'hFF;
    step();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL bp_y got=%h exp=00", out_y); end
    checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL bp_zero got=%b exp=1", out_zero); end
    checks++; if (out_parity !== 1'b0) begin failures++; $display("FAIL bp_parity got=%b exp=0", out_parity); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    in_op = 3'd0; in_a = 8'h0F; in_b = 8'hFF;
    step();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL bp_hold_y got=%h exp=00", out_y); end
    in_op = 3'd1; in_a = 8'h3C; in_b = 8'h00;
    step();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL bp_hold2_y got=%h exp=00", out_y); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_y !== 8'h3C) begin failures++; $display("FAIL bp_second_y got=%h exp=3c", out_y); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b exp=1", out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    checks++; if (acc_q !== 8'h3C) begin failures++; $display("FAIL bp_acc got=%h exp=3c", acc_q); end
  endtask

  task automatic test_acc_chain();
    out_ready = 1'b1;
    acc_clr = 1'b1; in_valid = 1'b0;
    step();
    checks++; if (acc_q !== ACC_INIT) begin failures++; $display("FAIL chain_clr got=%h exp=%h", acc_q, ACC_INIT); end
    acc_clr = 1'b0;
    in_valid = 1'b1; in_acc = 1'b1; in_op = 3'd1; in_a = 8'hAA; in_b = 8'h01;
    step();
    checks++; if (out_y !== 8'h01) begin failures++; $display("FAIL chain1_y got=%h exp=01", out_y); end
    checks++; if (acc_q !== 8'h01) begin failures++; $display("FAIL chain1_acc got=%h exp=01", acc_q); end
    in_b = 8'h80;
    step();
    checks++; if (out_y !== 8'h81) begin failures++; $display("FAIL chain2_y got=%h exp=81", out_y); end
    in_op = 3'd5; in_b = 8'h81;
    step();
    checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL chain3_y got=%h exp=00", out_y); end
    checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL chain3_zero got=%b exp=1", out_zero); end
    in_valid = 1'b0; in_acc = 1'b0;
    step();
  endtask

  task automatic test_acc_clr_accept();
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 1'b0; in_op = 3'd7; in_b = 8'h0F;
    step();
    checks++; if (acc_q !== 8'h0F) begin failures++; $display("FAIL clracc_pre got=%h exp=0f", acc_q); end
    in_acc = 1'b1; in_op = 3'd1; in_b = 8'hF0; acc_clr = 1'b1;
    step();
    checks++; if (out_y !== 8'hFF) begin failures++; $display("FAIL clracc_y got=%h exp=ff", out_y); end
    checks++; if (acc_q !== ACC_INIT) begin failures++; $display("FAIL clracc_acc got=%h exp=%h", acc_q, ACC_INIT); end
    acc_clr = 1'b0; in_valid = 1'b0; in_acc = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_b = 8'h5A;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_held got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    checks++; if (acc_q !== ACC_INIT) begin failures++; $display("FAIL rmid_acc got=%h exp=%h", acc_q, ACC_INIT); end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_post%0d got=%b exp=0", i, out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] model_acc;
    logic [WIDTH-1:0] res;
    logic exp_ready, do_x, do_a;
    int accepted, received, cyc;
    acc_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    acc_clr = 1'b0;
    model_acc = ACC_INIT;
    accepted = 0; received = 0; cyc = 0;
    while ((accepted < 16 || exp_q.size() != 0) && cyc < 400) begin
      in_valid  = (accepted < 16) && ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_acc    = $urandom_range(0, 1) == 1;
      acc_clr   = $urandom_range(0, 7) == 0;
      out_ready = (accepted >= 16) || ($urandom_range(0, 1) == 1);
      #1;
      exp_ready = (exp_q.size() == 0) || out_ready;
      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (out_y !== exp_q[0]) begin failures++; $display("FAIL stream_y cyc=%0d got=%h exp=%h", cyc, out_y, exp_q[0]); end
        checks++; if (out_zero !== (exp_q[0] == '0)) begin failures++; $display("FAIL stream_zero cyc=%0d got=%b exp=%b", cyc, out_zero, exp_q[0] == '0); end
        checks++; if (out_parity !== ref_par(exp_q[0])) begin failures++; $display("FAIL stream_parity cyc=%0d got=%b exp=%b", cyc, out_parity, ref_par(exp_q[0])); end
      end
      do_x = (exp_q.size() != 0) && out_ready;
      do_a = in_valid && exp_ready;
      res  = ref_op(in_op, in_acc ? model_acc : in_a, in_b);
      @(posedge clk);
      #1;
      if (do_x) begin void'(exp_q.pop_front()); received++; end
      if (do_a) begin exp_q.push_back(res); accepted++; end
      if (acc_clr) model_acc = ACC_INIT;
      else if (do_a) model_acc = res;
      checks++; if (acc_q !== model_acc) begin failures++; $display("FAIL stream_acc cyc=%0d got=%h exp=%h", cyc, acc_q, model_acc); end
      cyc++;
    end
    in_valid = 1'b0; acc_clr = 1'b0;
    checks++; if (cyc >= 400) begin failures++; $display("FAIL stream_timeout cyc=%0d limit=400", cyc); end
    checks++; if (received != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", received); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_final_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b0110; tt[6] = 4'b1001; tt[7] = 4'b1010;
    test_reset();
    test_opcodes();
    test_backpressure();
    test_acc_chain();
    test_acc_clr_accept();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
